// File: rtl/axi_sram_slave_if.sv
// AXI3 read/write channel bundle between a master and the SRAM responder.
// Carries address, data and response channels with their valid/ready pairs.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3 slave over a word-addressed SRAM; one read and one write outstanding, fully concurrent.
// First R beat RD_LAT+1 cycles after AR accept, then full rate; B one cycle after commit.
// rdata/rid/rlast hold under rready=0; AW/W readies drop once held until the B handshake.
module axi_sram_slave #(
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 1
) (
    input logic              aclk,
    input logic              aresetn,
    axi_sram_slave_if.slave  bus
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_COLLECT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_dat;
    logic [3:0]       wr_strb;

    // Merge a same-edge write so a beat loaded on the commit edge sees the new bytes.
    function automatic logic [31:0] rd_word(input logic [IDX_W-1:0] idx);
        logic [31:0] w;
        w = mem[idx];
        if (wr_en && (wr_idx == idx)) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) w[8*i +: 8] = wr_dat[8*i +: 8];
            end
        end
        return w;
    endfunction

    // ---------------- read side ----------------
    r_state_t         r_state, r_state_nxt;
    logic [31:0]      r_addr, r_addr_inc;
    logic [7:0]       r_len, r_beat;
    logic [2:0]       r_size;
    logic             r_fixed;
    logic [3:0]       r_lat;
    logic             ar_hs, ld_rdata, r_adv;
    logic [IDX_W-1:0] ld_idx;

    assign ar_hs      = bus.arvalid && bus.arready;
    assign r_addr_inc = r_fixed ? r_addr : r_addr + (32'd1 << r_size);
    assign bus.rvalid = (r_state == R_BURST);
    assign bus.rlast  = bus.rvalid && (r_beat == r_len);
    assign bus.rresp  = 2'b00;

    always_comb begin
        r_state_nxt = r_state;
        ld_rdata    = 1'b0;
        r_adv       = 1'b0;
        ld_idx      = r_addr[ADDR_W-1:2];
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_WAIT;
            R_WAIT: begin
                if (r_lat == 4'd1) begin
                    ld_rdata    = 1'b1;
                    r_state_nxt = R_BURST;
                end
            end
            R_BURST: begin
                if (bus.rready) begin
                    if (bus.rlast) begin
                        r_state_nxt = R_IDLE;
                    end else begin
                        r_adv    = 1'b1;
                        ld_rdata = 1'b1;
                        ld_idx   = r_addr_inc[ADDR_W-1:2];
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state     <= R_IDLE;
            bus.arready <= 1'b0;
            bus.rid     <= 4'd0;
            bus.rdata   <= 32'd0;
            r_addr      <= 32'd0;
            r_len       <= 8'd0;
            r_beat      <= 8'd0;
            r_size      <= 3'd0;
            r_fixed     <= 1'b0;
            r_lat       <= 4'd0;
        end else begin
            r_state     <= r_state_nxt;
            bus.arready <= (r_state_nxt == R_IDLE);
            if (ar_hs) begin
                bus.rid <= bus.arid;
                r_addr  <= bus.araddr;
                r_len   <= bus.arlen;
                r_size  <= bus.arsize;
                r_fixed <= (bus.arburst == 2'b00);
                r_lat   <= 4'(RD_LAT);
                r_beat  <= 8'd0;
            end else if (r_state == R_WAIT) begin
                r_lat <= r_lat - 4'd1;
            end
            if (ld_rdata) bus.rdata <= rd_word(ld_idx);
            if (r_adv) begin
                r_addr <= r_addr_inc;
                r_beat <= r_beat + 8'd1;
            end
        end
    end

    // ---------------- write side ----------------
    w_state_t    w_state, w_state_nxt;
    logic        aw_got, aw_got_nxt, w_got, w_got_nxt, w_seen, w_seen_nxt;
    logic [3:0]  aw_id_q;
    logic [31:0] aw_addr_q;
    logic [7:0]  aw_len_q;
    logic [31:0] wdat_q;
    logic [3:0]  wstrb_q;
    logic        aw_hs, w_hs, commit, awready_nxt, wready_nxt;
    logic [3:0]  cur_id;
    logic [31:0] cur_addr;
    logic [7:0]  cur_len;

    assign aw_hs    = bus.awvalid && bus.awready;
    assign w_hs     = bus.wvalid && bus.wready;
    assign cur_id   = aw_got ? aw_id_q   : bus.awid;
    assign cur_addr = aw_got ? aw_addr_q : bus.awaddr;
    assign cur_len  = aw_got ? aw_len_q  : bus.awlen;
    assign wr_dat   = w_seen ? wdat_q    : bus.wdata;
    assign wr_strb  = w_seen ? wstrb_q   : bus.wstrb;
    assign wr_idx   = cur_addr[ADDR_W-1:2];
    assign wr_en    = commit && (cur_len == 8'd0) && aresetn;
    assign bus.bvalid = (w_state == W_RESP);

    // W is only "held" at wlast so multi-beat bursts drain before the slave stalls wready.
    always_comb begin
        w_state_nxt = w_state;
        aw_got_nxt  = aw_got | aw_hs;
        w_got_nxt   = w_got | (w_hs & bus.wlast);
        w_seen_nxt  = w_seen | w_hs;
        commit      = 1'b0;
        case (w_state)
            W_IDLE, W_COLLECT: begin
                if (aw_got_nxt && w_got_nxt) begin
                    commit      = 1'b1;
                    w_state_nxt = W_RESP;
                end else if (aw_got_nxt || w_seen_nxt) begin
                    w_state_nxt = W_COLLECT;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_state_nxt = W_IDLE;
                    aw_got_nxt  = 1'b0;
                    w_got_nxt   = 1'b0;
                    w_seen_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
        awready_nxt = (w_state_nxt != W_RESP) && !aw_got_nxt;
        wready_nxt  = (w_state_nxt != W_RESP) && !w_got_nxt;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state     <= W_IDLE;
            aw_got      <= 1'b0;
            w_got       <= 1'b0;
            w_seen      <= 1'b0;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b0;
            bus.bid     <= 4'd0;
            bus.bresp   <= 2'b00;
            aw_id_q     <= 4'd0;
            aw_addr_q   <= 32'd0;
            aw_len_q    <= 8'd0;
            wdat_q      <= 32'd0;
            wstrb_q     <= 4'd0;
        end else begin
            w_state     <= w_state_nxt;
            aw_got      <= aw_got_nxt;
            w_got       <= w_got_nxt;
            w_seen      <= w_seen_nxt;
            bus.awready <= awready_nxt;
            bus.wready  <= wready_nxt;
            if (aw_hs) begin
                aw_id_q   <= bus.awid;
                aw_addr_q <= bus.awaddr;
                aw_len_q  <= bus.awlen;
            end
            if (w_hs && !w_seen) begin
                wdat_q  <= bus.wdata;
                wstrb_q <= bus.wstrb;
            end
            if (commit) begin
                bus.bid   <= cur_id;
                bus.bresp <= (cur_len == 8'd0) ? 2'b00 : 2'b10;
            end
        end
    end

    // SRAM contents survive reset.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_strb[i]) mem[wr_idx][8*i +: 8] <= wr_dat[8*i +: 8];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.arlock, bus.arcache, bus.arprot, bus.awsize, bus.awburst,
                         bus.awlock, bus.awcache, bus.awprot, bus.wid, cur_addr};
endmodule
